// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 strip driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StGap,
        StLoad,
        StSend
    } state_e;

    localparam int unsigned DEF_MAX_POS      = 109;
    localparam int unsigned DEF_T0H_CYCLES   = 20;
    localparam int unsigned DEF_T1H_CYCLES   = 40;
    localparam int unsigned DEF_BIT_CYCLES   = 63;
    localparam int unsigned DEF_RESET_CYCLES = 3000;
    localparam int unsigned BITS_PER_LED     = 24;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// NRZ encoder for one WS2812 bit: a start strobe launches a BIT_CYCLES-long period whose
// high time depends on the bit value; bit_done marks the last cycle of the period.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic high,
    output logic bit_done
);

    localparam int unsigned CntW = $clog2(BIT_CYCLES);

    logic            active_q, active_d;
    logic            bit_q, bit_d;
    logic            high_q, high_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] t_high;

    // high_q is computed one cycle ahead so the strip pin comes straight from a flop.
    always_comb begin
        t_high   = bit_q ? CntW'(T1H_CYCLES) : CntW'(T0H_CYCLES);
        bit_done = active_q && (cnt_q == CntW'(BIT_CYCLES - 1));
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        high_d   = 1'b0;
        if (start) begin
            active_d = 1'b1;
            bit_d    = bit_val;
            cnt_d    = '0;
            high_d   = 1'b1;
        end else if (bit_done) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d  = cnt_q + 1'b1;
            high_d = (cnt_d < t_high);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            high_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            high_q   <= high_d;
            cnt_q    <= cnt_d;
        end
    end

    assign high = high_q;

endmodule

// File: rtl/ws2812_strip_driver.sv
// Frame sequencer for a WS2812 strip: GAP latch, then per-LED LOAD/SEND of 24 GRB bits.
// Define GLOBAL_DIM_EN to send every channel at quarter brightness (value >> 2).
module ws2812_strip_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned MAX_POS      = DEF_MAX_POS,
    parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 led_green_intensity,
    input  logic [7:0]                 led_red_intensity,
    input  logic [7:0]                 led_blue_intensity,
    output logic [$clog2(MAX_POS)-1:0] current_led,
    output logic                       data_out,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned LedW = $clog2(MAX_POS);
    localparam int unsigned CntW = $clog2(RESET_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [LedW-1:0]         led_q, led_d;
    logic                    frame_done_q, frame_done_d;
    logic                    enc_start, enc_bit, enc_done;
    logic [BITS_PER_LED-1:0] word;

`ifdef GLOBAL_DIM_EN
    assign word = {2'b00, led_green_intensity[7:2],
                   2'b00, led_red_intensity[7:2],
                   2'b00, led_blue_intensity[7:2]};
`else
    assign word = {led_green_intensity, led_red_intensity, led_blue_intensity};
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        led_d        = led_q;
        frame_done_d = 1'b0;
        enc_start    = 1'b0;
        enc_bit      = shift_q[BITS_PER_LED-1];
        unique case (state_q)
            StGap: begin
                if (cnt_q == CntW'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoad: begin
                shift_d   = word;
                bit_cnt_d = '0;
                cnt_d     = '0;
                enc_start = 1'b1;
                enc_bit   = word[BITS_PER_LED-1];
                state_d   = StSend;
            end
            StSend: begin
                if (enc_done) begin
                    if (bit_cnt_q == 5'(BITS_PER_LED - 1)) begin
                        if (led_q == LedW'(MAX_POS - 1)) begin
                            led_d        = '0;
                            frame_done_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = StGap;
                        end else begin
                            led_d   = led_q + 1'b1;
                            state_d = StLoad;
                        end
                    end else begin
                        // Next bit starts back-to-back so every bit period is exact.
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        enc_start = 1'b1;
                        enc_bit   = shift_q[BITS_PER_LED-2];
                    end
                end
            end
            default: state_d = StGap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StGap;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            led_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    ws2812_bit_encoder #(
        .T0H_CYCLES(T0H_CYCLES),
        .T1H_CYCLES(T1H_CYCLES),
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_encoder (
        .clk     (clk),
        .rst     (rst),
        .start   (enc_start),
        .bit_val (enc_bit),
        .high    (data_out),
        .bit_done(enc_done)
    );

    assign current_led = led_q;
    assign busy        = (state_q != StGap);
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Scoreboard bench: decodes the strip waveform back into GRB words and checks timing.
module tb_ws2812_strip_driver;

    localparam int unsigned MAX_POS      = 3;
    localparam int unsigned T0H          = 20;
    localparam int unsigned T1H          = 40;
    localparam int unsigned BIT          = 63;
    localparam int unsigned RST_CYC      = 3000;
    localparam int unsigned LED_PERIOD   = 1 + 24 * BIT;
    localparam int unsigned FRAME_PERIOD = RST_CYC + MAX_POS * LED_PERIOD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] g, r, b;
    logic [1:0] current_led;
    logic       data_out, busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];
    logic [23:0] col_a[MAX_POS];
    logic [23:0] col_b[MAX_POS];

    always #5 clk = ~clk;

    ws2812_strip_driver #(
        .MAX_POS     (MAX_POS),
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BIT),
        .RESET_CYCLES(RST_CYC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .led_green_intensity(g),
        .led_red_intensity  (r),
        .led_blue_intensity (b),
        .current_led        (current_led),
        .data_out           (data_out),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] sent_word(input logic [23:0] grb);
        logic [7:0] gg, rr, bb;
        gg = grb[23:16];
        rr = grb[15:8];
        bb = grb[7:0];
`ifdef GLOBAL_DIM_EN
        gg = gg / 4;
        rr = rr / 4;
        bb = bb / 4;
`endif
        return {gg, rr, bb};
    endfunction

    task automatic new_frame();
        for (int i = 0; i < MAX_POS; i++) begin
            col_a[i] = 24'($urandom());
            col_b[i] = 24'($urandom());
            exp_q.push_back(sent_word(col_a[i]));
        end
    endtask

    task automatic wait_frame_done(input int limit);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = (frame_done === 1'b1);
        end
        check("frame_done within budget", {31'd0, seen}, 1);
        @(posedge clk);
        #1;
    endtask

    // Screen-stage model: stable colour around the capture, a different one mid-SEND.
    initial begin
        int         age;
        logic [1:0] prev_led;
        logic       prev_busy;
        age       = 0;
        prev_led  = '0;
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy === 1'b1 && prev_busy && current_led == prev_led) age++;
            else age = 0;
            prev_led  = current_led;
            prev_busy = busy;
            if (current_led < MAX_POS) {g, r, b} = (age < 50) ? col_a[current_led]
                                                                : col_b[current_led];
        end
    end

    // Monitor: rebuild bits from pulse widths, pop expected words, check periods.
    initial begin
        int          since_rst, hi, lo, last_hi, nbits, words, last_fd;
        logic        prev, first_rise, fd_seen;
        logic [1:0]  prev_led;
        logic [23:0] acc;
        since_rst = 0; hi = 0; lo = 0; last_hi = 0; nbits = 0; words = 0; last_fd = 0;
        prev = 1'b0; first_rise = 1'b1; fd_seen = 1'b0; prev_led = '0; acc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                since_rst = -1;
                hi = 0; lo = 0; nbits = 0; words = 0;
                prev = 1'b0; first_rise = 1'b1; fd_seen = 1'b0; prev_led = '0;
                continue;
            end
            since_rst++;
            if (data_out && !prev) begin
                check("busy while sending", {31'd0, busy}, 1);
                if (first_rise) begin
                    check("first rising edge cycle", since_rst, RST_CYC + 1);
                    first_rise = 1'b0;
                end else if (nbits != 0) begin
                    check("bit period", last_hi + lo, BIT);
                end else if (words != 0) begin
                    check("LED boundary period", last_hi + lo, BIT + 1);
                end else begin
                    check("frame boundary period", last_hi + lo, BIT + RST_CYC + 1);
                end
                hi = 1;
            end else if (data_out) begin
                hi++;
            end else if (prev) begin
                check("high pulse width legal", {31'd0, (hi == T0H || hi == T1H)}, 1);
                acc     = {acc[22:0], (hi == T1H)};
                last_hi = hi;
                lo      = 1;
                nbits++;
                if (nbits == 24) begin
                    nbits = 0;
                    words++;
                    if (exp_q.size() == 0) check("scoreboard underflow", 0, 1);
                    else check("LED word", acc, exp_q.pop_front());
                end
            end else begin
                lo++;
            end
            if (current_led != prev_led) begin
                check("current_led step", current_led, (int'(prev_led) + 1) % MAX_POS);
                prev_led = current_led;
            end
            if (frame_done === 1'b1) begin
                check("LEDs per frame", words, MAX_POS);
                check("busy low at frame_done", {31'd0, busy}, 0);
                check("frame period", fd_seen ? since_rst - last_fd : since_rst, FRAME_PERIOD);
                last_fd = since_rst;
                fd_seen = 1'b1;
                words   = 0;
            end
            prev = data_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MAX_POS; i++) begin
            col_a[i] = '0;
            col_b[i] = '0;
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset data_out", {31'd0, data_out}, 0);
        check("reset current_led", {30'd0, current_led}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset frame_done", {31'd0, frame_done}, 0);

        // Directed first frame: known GRB word, then a mid-SEND change from ones to zeros.
        col_a[0] = 24'hFF00A5;
        col_b[0] = 24'($urandom());
        col_a[1] = 24'hFFFFFF;
        col_b[1] = 24'h000000;
        col_a[2] = 24'h000000;
        col_b[2] = 24'($urandom());
        for (int i = 0; i < MAX_POS; i++) exp_q.push_back(sent_word(col_a[i]));
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_frame_done(FRAME_PERIOD + 100);

        for (int f = 0; f < 2; f++) begin
            new_frame();
            wait_frame_done(FRAME_PERIOD + 100);
        end

        // Abandon a frame during bit 10 of LED 1.
        new_frame();
        begin
            int n;
            n = 0;
            while (current_led !== 2'd1 && n < FRAME_PERIOD) begin
                @(negedge clk);
                n++;
            end
            check("reached LED 1", {31'd0, (current_led === 2'd1)}, 1);
        end
        repeat (1 + 10 * BIT + 5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid-frame reset data_out", {31'd0, data_out}, 0);
        check("mid-frame reset current_led", {30'd0, current_led}, 0);
        check("mid-frame reset busy", {31'd0, busy}, 0);
        check("mid-frame reset frame_done", {31'd0, frame_done}, 0);
        exp_q.delete();
        new_frame();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_frame_done(FRAME_PERIOD + 100);
        check("scoreboard drained", exp_q.size(), 0);

        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
